producer_line_packer: RTL and testbench

- Upstream stage of the Cohort producer path: packs a stream of narrow accelerator words into full-width producer transactions (512-bit line + 4-bit transaction id).
- Downstream, the producer queue writer consumes those transactions.
- One fill buffer plus one output register allow back-to-back lines at full word throughput.
- A flush input forces out a partial line at stream end.

---
 rtl/producer_line_packer_pkg.sv | 19 +
 rtl/producer_line_packer_id_counter.sv | 28 ++
 rtl/producer_line_packer.sv | 126 ++++++++++++
 tb/tb_producer_line_packer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/producer_line_packer_pkg.sv
// Producer transaction types plus the word-packing constants used by the line packer.
package producer_line_packer_pkg;

   localparam int LINE_WIDTH     = 512;
   localparam int ID_WIDTH       = 4;
   localparam int WORD_WIDTH     = 64;
   localparam int WORDS_PER_LINE = LINE_WIDTH / WORD_WIDTH;
   localparam int CNT_WIDTH      = $clog2(WORDS_PER_LINE + 1);

   typedef logic [LINE_WIDTH-1:0] data_t;
   typedef logic [ID_WIDTH-1:0]   id_t;
   typedef logic [WORD_WIDTH-1:0] word_t;
   typedef logic [CNT_WIDTH-1:0]  cnt_t;

   // Fill index of the word that completes a line, and the word count of a full line.
   localparam cnt_t LAST_IDX = cnt_t'(WORDS_PER_LINE - 1);
   localparam cnt_t FULL_CNT = cnt_t'(WORDS_PER_LINE);

endpackage

// File: rtl/producer_line_packer_id_counter.sv
// Wrapping transaction-id counter; advances by one whenever inc_i is high.
module producer_id_counter
   import producer_line_packer_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic inc_i,
   output id_t  id_o
);

   id_t id_q;
   id_t id_d;

   // Next id: natural wrap from all-ones back to zero.
   always_comb begin
      id_d = id_q;
      if (inc_i) id_d = id_q + id_t'(1);
   end

   // Id register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) id_q <= '0;
      else       id_q <= id_d;
   end

   assign id_o = id_q;

endmodule

// File: rtl/producer_line_packer.sv
// Packs narrow accelerator words into full producer lines with a transaction id.
// One fill buffer collects words; one output register presents the finished line.
module producer_line_packer
   import producer_line_packer_pkg::*;
(
   input  logic  clk_i,
   input  logic  rst_i,
   input  logic  word_valid_i,
   output logic  word_ready_o,
   input  word_t word_data_i,
   input  logic  flush_i,
   output logic  line_valid_o,
   input  logic  line_ready_i,
   output data_t line_data_o,
   output id_t   line_id_o,
   output cnt_t  line_count_o,
   output logic  idle_o
);

   cnt_t  fill_idx_q,   fill_idx_d;
   data_t fill_buf_q,   fill_buf_d;
   logic  flush_pend_q, flush_pend_d;
   logic  line_valid_q, line_valid_d;
   data_t line_data_q,  line_data_d;
   id_t   line_id_q,    line_id_d;
   cnt_t  line_count_q, line_count_d;

   logic  out_free;
   logic  ready;
   logic  accept;
   logic  last_word;
   logic  flush_xfer;
   logic  xfer;
   data_t merged;
   id_t   id_cur;

   // Handshake decode: ready never looks at word_valid_i; a pending flush blocks new words.
   always_comb begin
      out_free   = !line_valid_q || line_ready_i;
      ready      = !flush_pend_q && ((fill_idx_q != LAST_IDX) || out_free);
      accept     = word_valid_i && ready;
      last_word  = accept && (fill_idx_q == LAST_IDX);
      flush_xfer = flush_pend_q && out_free;
      xfer       = last_word || flush_xfer;
   end

   // Fill buffer with this cycle's accepted word dropped into its slot.
   always_comb begin
      merged = fill_buf_q;
      for (int k = 0; k < WORDS_PER_LINE; k++) begin
         if (accept && (fill_idx_q == cnt_t'(k))) merged[k*WORD_WIDTH +: WORD_WIDTH] = word_data_i;
      end
   end

   // Next state for fill side, flush tracking and output register.
   always_comb begin
      fill_idx_d   = fill_idx_q;
      fill_buf_d   = fill_buf_q;
      flush_pend_d = flush_pend_q;
      line_valid_d = line_valid_q;
      line_data_d  = line_data_q;
      line_id_d    = line_id_q;
      line_count_d = line_count_q;

      if (xfer) begin
         // A full line takes the merged buffer; a flushed line takes what was held,
         // whose unfilled slots are already zero because the buffer clears on transfer.
         line_valid_d = 1'b1;
         line_data_d  = last_word ? merged : fill_buf_q;
         line_count_d = last_word ? FULL_CNT : fill_idx_q;
         line_id_d    = id_cur;
         fill_idx_d   = '0;
         fill_buf_d   = '0;
      end else begin
         if (accept) begin
            fill_buf_d = merged;
            fill_idx_d = fill_idx_q + cnt_t'(1);
         end
         if (line_valid_q && line_ready_i) line_valid_d = 1'b0;
      end

      // A flush landing on the completing word is already satisfied by that full line;
      // a flush with nothing held and nothing arriving is dropped.
      if (flush_xfer) begin
         flush_pend_d = 1'b0;
      end else if (flush_i && !last_word && ((fill_idx_q != '0) || accept)) begin
         flush_pend_d = 1'b1;
      end
   end

   // State registers; reset discards any partial line.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fill_idx_q   <= '0;
         fill_buf_q   <= '0;
         flush_pend_q <= 1'b0;
         line_valid_q <= 1'b0;
         line_data_q  <= '0;
         line_id_q    <= '0;
         line_count_q <= '0;
      end else begin
         fill_idx_q   <= fill_idx_d;
         fill_buf_q   <= fill_buf_d;
         flush_pend_q <= flush_pend_d;
         line_valid_q <= line_valid_d;
         line_data_q  <= line_data_d;
         line_id_q    <= line_id_d;
         line_count_q <= line_count_d;
      end
   end

   producer_id_counter u_id_counter (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (xfer),
      .id_o  (id_cur)
   );

   assign word_ready_o = ready;
   assign line_valid_o = line_valid_q;
   assign line_data_o  = line_data_q;
   assign line_id_o    = line_id_q;
   assign line_count_o = line_count_q;
   assign idle_o       = (fill_idx_q == '0) && !line_valid_q && !flush_pend_q;

endmodule

// File: tb/tb_producer_line_packer.sv
// Directed bench for producer_line_packer with hand-computed expectations.
module tb_producer_line_packer;
   import producer_line_packer_pkg::*;

   logic  clk_i = 1'b0;
   logic  rst_i;
   logic  word_valid_i;
   logic  word_ready_o;
   word_t word_data_i;
   logic  flush_i;
   logic  line_valid_o;
   logic  line_ready_i;
   data_t line_data_o;
   id_t   line_id_o;
   cnt_t  line_count_o;
   logic  idle_o;

   int checks = 0;
   int errors = 0;

   producer_line_packer dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .word_valid_i (word_valid_i),
      .word_ready_o (word_ready_o),
      .word_data_i  (word_data_i),
      .flush_i      (flush_i),
      .line_valid_o (line_valid_o),
      .line_ready_i (line_ready_i),
      .line_data_o  (line_data_o),
      .line_id_o    (line_id_o),
      .line_count_o (line_count_o),
      .idle_o       (idle_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   // Line with words base, base+1, ... in slots 0..n-1 and zero above.
   function automatic data_t mk(input word_t base, input int n);
      data_t r = '0;
      for (int k = 0; k < n; k++) r[k*WORD_WIDTH +: WORD_WIDTH] = base + word_t'(k);
      return r;
   endfunction

   initial begin
      #100000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst_i = 1'b1; word_valid_i = 1'b0; word_data_i = '0; flush_i = 1'b0; line_ready_i = 1'b1;
      repeat (2) cyc();

      // ---- reset state
      chk("rst_valid", 512'(line_valid_o), 512'd0);
      chk("rst_data",  line_data_o, '0);
      chk("rst_id",    512'(line_id_o), 512'd0);
      chk("rst_count", 512'(line_count_o), 512'd0);
      chk("rst_ready", 512'(word_ready_o), 512'd1);
      chk("rst_idle",  512'(idle_o), 512'd1);
      rst_i = 1'b0;

      // ---- 8 words 0x1..0x8 -> line id 0
      for (int k = 1; k <= 8; k++) begin
         word_valid_i = 1'b1; word_data_i = word_t'(k);
         #1 chk("t1_ready", 512'(word_ready_o), 512'd1);
         cyc();
      end
      word_valid_i = 1'b0;
      chk("t1_valid", 512'(line_valid_o), 512'd1);
      chk("t1_count", 512'(line_count_o), 512'd8);
      chk("t1_id",    512'(line_id_o), 512'd0);
      chk("t1_w0",    512'(line_data_o[63:0]), 512'h1);
      chk("t1_w7",    512'(line_data_o[511:448]), 512'h8);
      chk("t1_data",  line_data_o, mk(64'h1, 8));
      cyc();
      chk("t1_drain", 512'(line_valid_o), 512'd0);
      chk("t1_idle",  512'(idle_o), 512'd1);

      // ---- 16 continuous words -> ids 1 and 2, ready never drops
      for (int k = 0; k < 16; k++) begin
         word_valid_i = 1'b1; word_data_i = 64'h10 + word_t'(k);
         #1 chk("t2_ready", 512'(word_ready_o), 512'd1);
         cyc();
         if (k == 7) begin
            chk("t2_l0_valid", 512'(line_valid_o), 512'd1);
            chk("t2_l0_id",    512'(line_id_o), 512'd1);
            chk("t2_l0_data",  line_data_o, mk(64'h10, 8));
         end
      end
      word_valid_i = 1'b0;
      chk("t2_l1_valid", 512'(line_valid_o), 512'd1);
      chk("t2_l1_id",    512'(line_id_o), 512'd2);
      chk("t2_l1_data",  line_data_o, mk(64'h18, 8));
      cyc();
      chk("t2_drain", 512'(line_valid_o), 512'd0);

      // ---- backpressure: 16 words offered with line_ready_i low
      line_ready_i = 1'b0;
      for (int k = 0; k < 15; k++) begin
         word_valid_i = 1'b1; word_data_i = 64'h20 + word_t'(k);
         #1 chk("t3_ready", 512'(word_ready_o), 512'd1);
         cyc();
      end
      word_data_i = 64'h2F;
      #1;
      chk("t3_stall_ready", 512'(word_ready_o), 512'd0);
      chk("t3_hold_valid",  512'(line_valid_o), 512'd1);
      chk("t3_hold_id",     512'(line_id_o), 512'd3);
      chk("t3_hold_data",   line_data_o, mk(64'h20, 8));
      cyc(); cyc();
      chk("t3_stall_ready2", 512'(word_ready_o), 512'd0);
      chk("t3_hold_id2",     512'(line_id_o), 512'd3);
      chk("t3_hold_data2",   line_data_o, mk(64'h20, 8));
      chk("t3_hold_count2",  512'(line_count_o), 512'd8);
      line_ready_i = 1'b1;
      #1 chk("t3_ready_open", 512'(word_ready_o), 512'd1);
      cyc();
      word_valid_i = 1'b0;
      chk("t3_l1_valid", 512'(line_valid_o), 512'd1);
      chk("t3_l1_id",    512'(line_id_o), 512'd4);
      chk("t3_l1_data",  line_data_o, mk(64'h28, 8));
      cyc();
      chk("t3_drain", 512'(line_valid_o), 512'd0);

      // ---- partial line 0xA,0xB,0xC then flush
      for (int k = 0; k < 3; k++) begin
         word_valid_i = 1'b1; word_data_i = 64'hA + word_t'(k);
         cyc();
      end
      word_valid_i = 1'b0;
      flush_i = 1'b1;
      cyc();
      flush_i = 1'b0;
      chk("t4_pend_ready", 512'(word_ready_o), 512'd0);
      chk("t4_pend_idle",  512'(idle_o), 512'd0);
      cyc();
      chk("t4_valid", 512'(line_valid_o), 512'd1);
      chk("t4_count", 512'(line_count_o), 512'd3);
      chk("t4_id",    512'(line_id_o), 512'd5);
      chk("t4_data",  line_data_o, mk(64'hA, 3));
      cyc();
      chk("t4_idle",  512'(idle_o), 512'd1);
      // flush with an empty fill emits nothing
      flush_i = 1'b1;
      cyc();
      flush_i = 1'b0;
      chk("t4_eflush_idle", 512'(idle_o), 512'd1);
      cyc();
      chk("t4_eflush_valid", 512'(line_valid_o), 512'd0);
      // flush on the same cycle as a word includes that word
      word_valid_i = 1'b1; word_data_i = 64'h30;
      cyc();
      word_data_i = 64'h31; flush_i = 1'b1;
      cyc();
      word_valid_i = 1'b0; flush_i = 1'b0;
      cyc();
      chk("t4b_valid", 512'(line_valid_o), 512'd1);
      chk("t4b_count", 512'(line_count_o), 512'd2);
      chk("t4b_id",    512'(line_id_o), 512'd6);
      chk("t4b_data",  line_data_o, mk(64'h30, 2));
      cyc();

      // ---- 17 lines: ids 7..15, wrap to 0..7; last one flushed on its 8th word
      for (int n = 0; n < 17; n++) begin
         for (int k = 0; k < 8; k++) begin
            word_valid_i = 1'b1; word_data_i = word_t'((n << 8) | k);
            flush_i = (n == 16 && k == 7);
            cyc();
         end
         word_valid_i = 1'b0; flush_i = 1'b0;
         chk("t5_valid", 512'(line_valid_o), 512'd1);
         chk("t5_id",    512'(line_id_o), 512'(id_t'(7 + n)));
      end
      chk("t5_last_count", 512'(line_count_o), 512'd8);
      cyc();
      chk("t5_one_line_a", 512'(line_valid_o), 512'd0);
      cyc();
      chk("t5_one_line_b", 512'(line_valid_o), 512'd0);
      chk("t5_idle",       512'(idle_o), 512'd1);

      // ---- async reset after 5 words
      for (int k = 0; k < 5; k++) begin
         word_valid_i = 1'b1; word_data_i = 64'h40 + word_t'(k);
         cyc();
      end
      word_valid_i = 1'b0;
      #2 rst_i = 1'b1;
      #1;
      chk("t6a_idle",  512'(idle_o), 512'd1);
      chk("t6a_ready", 512'(word_ready_o), 512'd1);
      cyc();
      rst_i = 1'b0;
      // async reset while a line is held under backpressure
      line_ready_i = 1'b0;
      for (int k = 0; k < 8; k++) begin
         word_valid_i = 1'b1; word_data_i = 64'h50 + word_t'(k);
         cyc();
      end
      word_valid_i = 1'b0;
      chk("t6b_valid", 512'(line_valid_o), 512'd1);
      chk("t6b_id",    512'(line_id_o), 512'd0);
      chk("t6b_data",  line_data_o, mk(64'h50, 8));
      #2 rst_i = 1'b1;
      #1;
      chk("t6b_rst_valid", 512'(line_valid_o), 512'd0);
      chk("t6b_rst_data",  line_data_o, '0);
      chk("t6b_rst_id",    512'(line_id_o), 512'd0);
      chk("t6b_rst_count", 512'(line_count_o), 512'd0);
      chk("t6b_rst_idle",  512'(idle_o), 512'd1);
      cyc();
      rst_i = 1'b0; line_ready_i = 1'b1;
      for (int k = 0; k < 8; k++) begin
         word_valid_i = 1'b1; word_data_i = 64'h60 + word_t'(k);
         cyc();
      end
      word_valid_i = 1'b0;
      chk("t6c_valid", 512'(line_valid_o), 512'd1);
      chk("t6c_id",    512'(line_id_o), 512'd0);
      chk("t6c_count", 512'(line_count_o), 512'd8);
      chk("t6c_data",  line_data_o, mk(64'h60, 8));
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
